// File: rtl/hub75_rx.sv
// hub75_rx: receiving end of a HUB75 panel bus.
// The bus lines are synchronized into clk. Each SCLK rise stores one
// {rgb1,rgb0} pixel pair in the active half of a ping-pong line buffer.
// A LATCH swaps the two halves and replays the completed row as a stream
// of pixel writes, while the next row is shifted into the other half.
module hub75_rx #(
    parameter int WIDTH = 64,
    parameter int XBITS = 6,
    parameter int YBITS = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hub_sclk,
    input  logic             hub_latch,
    input  logic             hub_blank,
    input  logic [YBITS-1:0] hub_addry,
    input  logic [2:0]       hub_rgb0,
    input  logic [2:0]       hub_rgb1,
    output logic             pix_valid,
    output logic [XBITS-1:0] pix_x,
    output logic [YBITS-1:0] pix_y,
    output logic [2:0]       pix_rgb0,
    output logic [2:0]       pix_rgb1,
    output logic             row_done,
    output logic             frame_start,
    output logic             blank_out,
    output logic             err_overflow,
    output logic             err_overrun
);

    // Synchronized bundle layout: {sclk, latch, blank, addry, rgb1, rgb0}
    localparam int SW = 3 + YBITS + 6;
    localparam logic [XBITS:0] FULL    = (XBITS+1)'(WIDTH);
    localparam logic [XBITS:0] CNT_ONE = (XBITS+1)'(1);
    localparam logic [XBITS-1:0] X_ONE = XBITS'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DUMP,
        ST_FLUSH
    } state_t;

    // Synchronizer stages
    logic [SW-1:0]    sync1_q;
    logic [SW-1:0]    sync2_q;
    logic             sclk_q3;
    logic             latch_q3;

    // Fields of the second synchronizer stage
    logic             sclk_s;
    logic             latch_s;
    logic             blank_s;
    logic [YBITS-1:0] addry_s;
    logic [5:0]       data_s;

    logic             sclk_rise;
    logic             latch_rise;

    // Shift side
    logic [XBITS:0]   shift_cnt_q;
    logic [XBITS:0]   shift_cnt_d;
    logic             shift_full;
    logic             active_q;
    logic             wr_en;
    logic [XBITS:0]   wr_addr;

    // Replay side
    state_t           state_q;
    logic [YBITS-1:0] row_y_q;
    logic [XBITS:0]   n_q;
    logic [XBITS-1:0] rd_x_q;
    logic             rd_last;
    logic             rd_en;
    logic [XBITS:0]   rd_addr;
    logic             first_q;

    // Line buffer: two halves of WIDTH entries, selected by the top address bit
    logic [5:0]       mem [0:2*WIDTH-1];
    logic [5:0]       rd_data_q;

    // Registered outputs
    logic             pix_valid_q;
    logic [XBITS-1:0] pix_x_q;
    logic [YBITS-1:0] pix_y_q;
    logic             row_done_q;
    logic             frame_start_q;
    logic             err_overflow_q;
    logic             err_overrun_q;

    assign {sclk_s, latch_s, blank_s, addry_s, data_s} = sync2_q;

    // Events come from the same stage as the data/address they qualify
    assign sclk_rise  = sclk_s & ~sclk_q3;
    assign latch_rise = latch_s & ~latch_q3;

    // A full row keeps its count at WIDTH; further pixels are dropped
    assign shift_full  = (shift_cnt_q == FULL);
    assign wr_en       = sclk_rise & ~shift_full;
    assign wr_addr     = {active_q, shift_cnt_q[XBITS-1:0]};
    // Count including a pixel that lands on the same cycle as a latch
    assign shift_cnt_d = wr_en ? (shift_cnt_q + CNT_ONE) : shift_cnt_q;

    // Replay always reads the half that is not being shifted into
    assign rd_en   = (state_q == ST_DUMP);
    assign rd_addr = {~active_q, rd_x_q};
    assign rd_last = ({1'b0, rd_x_q} == (n_q - CNT_ONE));

    // Pixel data comes straight from the RAM read register, forced to
    // zero whenever no pixel is being presented (including reset)
    assign pix_valid    = pix_valid_q;
    assign pix_x        = pix_x_q;
    assign pix_y        = pix_y_q;
    assign pix_rgb0     = pix_valid_q ? rd_data_q[2:0] : 3'b000;
    assign pix_rgb1     = pix_valid_q ? rd_data_q[5:3] : 3'b000;
    assign row_done     = row_done_q;
    assign frame_start  = frame_start_q;
    assign blank_out    = blank_s;
    assign err_overflow = err_overflow_q;
    assign err_overrun  = err_overrun_q;

    // Two-flop synchronizer for all bus lines plus an edge-detect stage on sclk/latch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            sclk_q3  <= 1'b0;
            latch_q3 <= 1'b0;
        end else begin
            sync1_q  <= {hub_sclk, hub_latch, hub_blank, hub_addry, hub_rgb1, hub_rgb0};
            sync2_q  <= sync1_q;
            sclk_q3  <= sclk_s;
            latch_q3 <= latch_s;
        end
    end

    // Line buffer: one write port for shifting, one registered read port for replay
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= data_s;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    // Shift counter, buffer swap, error flags and the replay FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            shift_cnt_q    <= '0;
            active_q       <= 1'b0;
            row_y_q        <= '0;
            n_q            <= '0;
            rd_x_q         <= '0;
            first_q        <= 1'b0;
            pix_valid_q    <= 1'b0;
            pix_x_q        <= '0;
            pix_y_q        <= '0;
            row_done_q     <= 1'b0;
            frame_start_q  <= 1'b0;
            err_overflow_q <= 1'b0;
            err_overrun_q  <= 1'b0;
        end else begin
            pix_valid_q   <= 1'b0;
            row_done_q    <= 1'b0;
            frame_start_q <= 1'b0;
            shift_cnt_q   <= shift_cnt_d;

            if (sclk_rise && shift_full) begin
                err_overflow_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                end
                ST_DUMP: begin
                    // The read issued on this edge becomes the presented pixel
                    pix_valid_q   <= 1'b1;
                    pix_x_q       <= rd_x_q;
                    pix_y_q       <= row_y_q;
                    frame_start_q <= first_q && (row_y_q == '0);
                    first_q       <= 1'b0;
                    if (rd_last) begin
                        state_q <= ST_FLUSH;
                    end else begin
                        rd_x_q <= rd_x_q + X_ONE;
                    end
                end
                ST_FLUSH: begin
                    // Also the only slot of an empty row, so frame_start may fire here
                    row_done_q    <= 1'b1;
                    frame_start_q <= first_q && (row_y_q == '0);
                    first_q       <= 1'b0;
                    state_q       <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase

            if (latch_rise) begin
                shift_cnt_q <= '0;
                if (state_q != ST_IDLE) begin
                    // Previous row still replaying: drop the new row, keep the buffers
                    err_overrun_q <= 1'b1;
                end else begin
                    row_y_q  <= addry_s;
                    n_q      <= shift_cnt_d;
                    active_q <= ~active_q;
                    rd_x_q   <= '0;
                    first_q  <= 1'b1;
                    state_q  <= (shift_cnt_d != '0) ? ST_DUMP : ST_FLUSH;
                end
            end
        end
    end

endmodule

// File: tb/tb_hub75_rx.sv
// Self-checking bench for hub75_rx. A reference model turns each bus event
// (delayed by the fixed synchronizer latency) into a per-cycle table of
// expected outputs, and a compare process checks the DUT against it.
module tb_hub75_rx;
    localparam int WIDTH = 64;
    localparam int XBITS = 6;
    localparam int YBITS = 5;
    localparam int MAXC  = 30000;
    localparam int ASZ   = MAXC + WIDTH + 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             hub_sclk = 1'b0;
    logic             hub_latch = 1'b0;
    logic             hub_blank = 1'b0;
    logic [YBITS-1:0] hub_addry = '0;
    logic [2:0]       hub_rgb0 = '0;
    logic [2:0]       hub_rgb1 = '0;
    logic             pix_valid;
    logic [XBITS-1:0] pix_x;
    logic [YBITS-1:0] pix_y;
    logic [2:0]       pix_rgb0;
    logic [2:0]       pix_rgb1;
    logic             row_done;
    logic             frame_start;
    logic             blank_out;
    logic             err_overflow;
    logic             err_overrun;

    hub75_rx #(.WIDTH(WIDTH), .XBITS(XBITS), .YBITS(YBITS)) dut (
        .clk(clk), .reset(reset),
        .hub_sclk(hub_sclk), .hub_latch(hub_latch), .hub_blank(hub_blank),
        .hub_addry(hub_addry), .hub_rgb0(hub_rgb0), .hub_rgb1(hub_rgb1),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .pix_rgb0(pix_rgb0), .pix_rgb1(pix_rgb1),
        .row_done(row_done), .frame_start(frame_start), .blank_out(blank_out),
        .err_overflow(err_overflow), .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    // Observed-output tallies
    int tot_pix = 0, tot_done = 0, tot_fs = 0;
    int last_x = -1, last_rgb0 = -1, last_rgb1 = -1;
    int p0, d0, f0;

    // Model: events scheduled to take effect on a given edge
    bit act_sclk  [ASZ];
    bit act_latch [ASZ];
    int act_data  [ASZ];
    int act_addr  [ASZ];
    // Model: expected outputs after a given edge
    bit exp_valid [ASZ];
    int exp_x     [ASZ];
    int exp_y     [ASZ];
    int exp_d     [ASZ];
    bit exp_done  [ASZ];
    bit exp_fs    [ASZ];
    bit exp_blank [ASZ];
    bit exp_ovf   [ASZ];
    bit exp_ovr   [ASZ];
    // Model: pixels shifted since the last latch
    int rowbuf [WIDTH];
    int m_cnt = 0;
    bit m_ovf = 0, m_ovr = 0;
    int busy_until = -100;
    bit prev_sclk = 0, prev_latch = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    // Reference model, evaluated on every rising clk edge
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (cyc < MAXC) begin
            if (reset) begin
                for (int i = cyc; i < cyc + WIDTH + 4; i++) begin
                    act_sclk[i] = 0; act_latch[i] = 0;
                    exp_valid[i] = 0; exp_done[i] = 0; exp_fs[i] = 0;
                    exp_blank[i] = 0; exp_ovf[i] = 0; exp_ovr[i] = 0;
                end
                m_cnt = 0; m_ovf = 0; m_ovr = 0; busy_until = -100;
                prev_sclk = 0; prev_latch = 0;
            end else begin
                // A rise sampled now acts two edges later; blank shows one edge later
                act_sclk[cyc+2]  = hub_sclk & ~prev_sclk;
                act_latch[cyc+2] = hub_latch & ~prev_latch;
                act_data[cyc+2]  = int'({hub_rgb1, hub_rgb0});
                act_addr[cyc+2]  = int'(hub_addry);
                exp_blank[cyc+1] = hub_blank;
                prev_sclk  = hub_sclk;
                prev_latch = hub_latch;
                // Pixel first, then latch
                if (act_sclk[cyc]) begin
                    if (m_cnt < WIDTH) begin
                        rowbuf[m_cnt] = act_data[cyc];
                        m_cnt++;
                    end else begin
                        m_ovf = 1;
                    end
                end
                if (act_latch[cyc]) begin
                    if (cyc <= busy_until) begin
                        m_ovr = 1;
                    end else begin
                        for (int i = 0; i < m_cnt; i++) begin
                            exp_valid[cyc+1+i] = 1;
                            exp_x[cyc+1+i] = i;
                            exp_y[cyc+1+i] = act_addr[cyc];
                            exp_d[cyc+1+i] = rowbuf[i];
                        end
                        exp_done[cyc+m_cnt+1] = 1;
                        if (act_addr[cyc] == 0) exp_fs[cyc+1] = 1;
                        busy_until = cyc + m_cnt + 1;
                    end
                    m_cnt = 0;
                end
                exp_ovf[cyc] = m_ovf;
                exp_ovr[cyc] = m_ovr;
            end
        end
    end

    // Compare DUT against the model away from the active edge
    always @(negedge clk) begin
        if (!reset && cyc > 0 && cyc < MAXC) begin
            chk("pix_valid", int'(pix_valid), int'(exp_valid[cyc]));
            if (exp_valid[cyc]) begin
                chk("pix_x", int'(pix_x), exp_x[cyc]);
                chk("pix_y", int'(pix_y), exp_y[cyc]);
                chk("pix_rgb0", int'(pix_rgb0), exp_d[cyc] & 7);
                chk("pix_rgb1", int'(pix_rgb1), (exp_d[cyc] >> 3) & 7);
            end
            chk("row_done", int'(row_done), int'(exp_done[cyc]));
            chk("frame_start", int'(frame_start), int'(exp_fs[cyc]));
            chk("blank_out", int'(blank_out), int'(exp_blank[cyc]));
            chk("err_overflow", int'(err_overflow), int'(exp_ovf[cyc]));
            chk("err_overrun", int'(err_overrun), int'(exp_ovr[cyc]));
            if (pix_valid) begin
                tot_pix++;
                last_x = int'(pix_x);
                last_rgb0 = int'(pix_rgb0);
                last_rgb1 = int'(pix_rgb1);
            end
            if (row_done) tot_done++;
            if (frame_start) tot_fs++;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic sclk_pulse(input logic [2:0] r0, input logic [2:0] r1, input int hi, input int lo);
        hub_rgb0 = r0;
        hub_rgb1 = r1;
        hub_blank = 1'($urandom);
        hub_sclk = 1'b1;
        repeat (hi) step();
        hub_sclk = 1'b0;
        repeat (lo) step();
    endtask

    task automatic latch_pulse(input int y);
        hub_addry = YBITS'(y);
        hub_latch = 1'b1;
        repeat (2) step();
        hub_latch = 1'b0;
        step();
    endtask

    task automatic snap();
        p0 = tot_pix; d0 = tot_done; f0 = tot_fs;
    endtask

    task automatic row_counts(input string tag, input int np, input int nd, input int nf);
        chk({tag, "_pixels"}, tot_pix - p0, np);
        chk({tag, "_row_done"}, tot_done - d0, nd);
        chk({tag, "_frame_start"}, tot_fs - f0, nf);
    endtask

    task automatic nominal_row(input int y);
        logic [2:0] v;
        for (int x = 0; x < WIDTH; x++) begin
            v = 3'(x);
            sclk_pulse(v, ~v, 2, 2);
        end
        latch_pulse(y);
        repeat (90) step();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pix_valid"}, int'(pix_valid), 0);
        chk({tag, "_pix_x"}, int'(pix_x), 0);
        chk({tag, "_pix_y"}, int'(pix_y), 0);
        chk({tag, "_pix_rgb0"}, int'(pix_rgb0), 0);
        chk({tag, "_pix_rgb1"}, int'(pix_rgb1), 0);
        chk({tag, "_row_done"}, int'(row_done), 0);
        chk({tag, "_frame_start"}, int'(frame_start), 0);
        chk({tag, "_blank_out"}, int'(blank_out), 0);
        chk({tag, "_err_overflow"}, int'(err_overflow), 0);
        chk({tag, "_err_overrun"}, int'(err_overrun), 0);
    endtask

    initial begin : main
        bit found;
        logic [2:0] v;

        reset = 1'b1;
        repeat (3) step();
        check_reset_outputs("reset");
        reset = 1'b0;
        repeat (4) step();

        // Nominal row at addry 5
        snap();
        nominal_row(5);
        row_counts("nominal", 64, 1, 0);
        chk("nominal_last_x", last_x, 63);
        chk("nominal_last_rgb0", last_rgb0, 7);
        chk("nominal_last_rgb1", last_rgb1, 0);
        chk("nominal_err_overflow", int'(err_overflow), 0);
        chk("nominal_err_overrun", int'(err_overrun), 0);

        // Full frame of random pixels, sclk at clk/4, replay overlapping the next row
        snap();
        for (int r = 0; r < 32; r++) begin
            for (int x = 0; x < WIDTH; x++) sclk_pulse(3'($urandom), 3'($urandom), 2, 2);
            latch_pulse(r);
        end
        repeat (100) step();
        row_counts("frame", 2048, 32, 1);

        // Short row with random sclk timing
        snap();
        for (int x = 0; x < 10; x++)
            sclk_pulse(3'($urandom), 3'($urandom), $urandom_range(1, 3), $urandom_range(2, 3));
        latch_pulse(7);
        repeat (40) step();
        row_counts("short", 10, 1, 0);
        chk("short_last_x", last_x, 9);

        // Empty row on row 0: only row_done and frame_start
        snap();
        latch_pulse(0);
        repeat (20) step();
        row_counts("empty", 0, 1, 1);
        chk("empty_err_overrun", int'(err_overrun), 0);

        // Last pixel coincides with the latch
        snap();
        for (int x = 0; x < 5; x++) sclk_pulse(3'($urandom), 3'($urandom), 2, 2);
        hub_rgb0 = 3'($urandom);
        hub_rgb1 = 3'($urandom);
        hub_addry = YBITS'(3);
        hub_sclk = 1'b1;
        hub_latch = 1'b1;
        repeat (2) step();
        hub_sclk = 1'b0;
        hub_latch = 1'b0;
        repeat (30) step();
        row_counts("coincident", 6, 1, 0);
        chk("coincident_last_x", last_x, 5);

        // Overflow: 70 pixels, only the first 64 replay
        snap();
        for (int x = 0; x < 70; x++) begin
            v = 3'(x);
            sclk_pulse(v, 3'($urandom), 2, 2);
        end
        latch_pulse(12);
        repeat (90) step();
        row_counts("overflow", 64, 1, 0);
        chk("overflow_last_x", last_x, 63);
        chk("overflow_last_rgb0", last_rgb0, 7);
        chk("overflow_flag", int'(err_overflow), 1);

        // Overrun: second latch arrives while the first row replays
        snap();
        for (int x = 0; x < WIDTH; x++) sclk_pulse(3'($urandom), 3'($urandom), 2, 2);
        latch_pulse(20);
        for (int x = 0; x < 3; x++) sclk_pulse(3'($urandom), 3'($urandom), 2, 2);
        latch_pulse(21);
        repeat (100) step();
        row_counts("overrun", 64, 1, 0);
        chk("overrun_flag", int'(err_overrun), 1);
        chk("overflow_sticky", int'(err_overflow), 1);
        snap();
        nominal_row(22);
        row_counts("after_overrun", 64, 1, 0);
        chk("after_overrun_last_x", last_x, 63);

        // Reset in the middle of a replay, at pixel 30
        for (int x = 0; x < WIDTH; x++) sclk_pulse(3'($urandom), 3'($urandom), 2, 2);
        latch_pulse(4);
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            step();
            if (pix_valid && pix_x == XBITS'(30)) found = 1;
        end
        chk("reset_trigger_seen", int'(found), 1);
        reset = 1'b1;
        #1;
        check_reset_outputs("midreset");
        repeat (3) step();
        reset = 1'b0;
        repeat (4) step();
        snap();
        nominal_row(9);
        row_counts("after_reset", 64, 1, 0);
        chk("after_reset_last_x", last_x, 63);
        chk("after_reset_err_overflow", int'(err_overflow), 0);
        chk("after_reset_err_overrun", int'(err_overrun), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #(MAXC * 10);
        n_cmp++;
        n_fail++;
        $display("FAIL watchdog: got timeout at cyc %0d expected completion", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hub75_rx.md
Name: hub75_rx

Overview:
- Receiving end of the HUB75 LED-panel bus that the panel scanner drives.
- Samples the external SCLK/LATCH/BLANK/ADDRY/RGB0/RGB1 lines, shifts each clocked pixel pair into a ping-pong line buffer, and on every LATCH replays the completed row as a pixel-write stream.
- Used for scanner loopback verification and as the input stage of a panel emulator / daisy-chain repeater.
- The stream feeds a framebuffer RAM directly; there is no backpressure.

Parameters:
- WIDTH, 64: pixels shifted per row (power of 2, 4..256).
- XBITS, 6: log2(WIDTH).
- YBITS, 5: row-address width (matches ADDRY).

Ports:
- clk  in  1  system clock; must be at least 3x the HUB75 SCLK frequency.
- reset  in  1  asynchronous, active-high reset.
- hub_sclk  in  1  HUB75 shift clock (asynchronous to clk).
- hub_latch  in  1  HUB75 latch.
- hub_blank  in  1  HUB75 blank/OE.
- hub_addry  in  YBITS  HUB75 row address.
- hub_rgb0  in  3  upper-half pixel bits {B,G,R}.
- hub_rgb1  in  3  lower-half pixel bits {B,G,R}.
- pix_valid  out  1  one write strobe per replayed pixel.
- pix_x  out  XBITS  column of the replayed pixel.
- pix_y  out  YBITS  row address captured at latch.
- pix_rgb0  out  3  upper-half pixel.
- pix_rgb1  out  3  lower-half pixel.
- row_done  out  1  1-cycle pulse after the last pixel of a row.
- frame_start  out  1  1-cycle pulse when a latched row address is 0.
- blank_out  out  1  synchronized hub_blank.
- err_overflow  out  1  sticky: more than WIDTH SCLK edges between latches.
- err_overrun  out  1  sticky: latch arrived while the previous row was still replaying.

Behaviour:
- Synchronization:
  - All hub_* inputs pass through a 2-flop synchronizer, plus a third stage on sclk and latch for edge detection.
  - Events are the rising edges of the synchronized sclk and latch.
  - Data/addr are sampled from the same synchronizer stage as the detected edge.
  - Fixed input-to-event latency: 3 clk.
- Shift side:
  - Each sclk rise writes {rgb1,rgb0} into the active buffer at shift_cnt, then increments shift_cnt.
  - At shift_cnt == WIDTH: the write is suppressed, shift_cnt saturates, err_overflow is set.
- Latch (no replay in progress):
  - Capture addry into row_y and n = shift_cnt.
  - Swap active/replay buffers; clear shift_cnt to 0.
  - If n > 0, start replay next cycle.
  - If n == 0: no pixels; row_done still pulses once, 1 cycle after the latch event.
- Latch during replay:
  - Set err_overrun, clear shift_cnt, no swap.
  - The in-progress replay continues unaffected; the aborted row's shifted data is discarded.
- sclk and latch on the same clk:
  - The pixel is written first at shift_cnt, then the latch uses n = shift_cnt+1 (saturated at WIDTH).
- Replay FSM:
  - IDLE: wait for a latch with n > 0, then go to DUMP.
  - DUMP: read replay buffer address rd_x (0..n-1), one per clk. After 1-cycle RAM read latency, drive pix_valid=1 with pix_x=rd_x, pix_y=row_y and the data.
  - After pixel n-1 is output: row_done pulses on the following cycle, then return to IDLE.
  - Throughput: n pixels in n+1 cycles, plus a 1-cycle row_done slot.
  - frame_start pulses in the same cycle as the first pix_valid of a row whose row_y == 0 (for n == 0, together with row_done).
- Concurrency:
  - Shifting into the active buffer proceeds concurrently with replay of the other buffer.
  - Replay at 1 pixel/clk always finishes before WIDTH new sclk edges can arrive (clk ≥ 3x sclk).
- blank_out = synchronized hub_blank. It does not gate capture.
- Reset (asynchronous, active-high):
  - Outputs: pix_valid, row_done, frame_start = 0; pix_x, pix_y, pix_rgb0/1 = 0; blank_out = 0; err flags = 0.
  - Internal: shift_cnt = 0, FSM = IDLE, active buffer = 0.
  - Buffer RAM contents are undefined.
  - Reset mid-replay aborts with no further pix_valid; the first latch after release behaves normally.
- Errors: err_* clear only on reset.

Test Plan:
- Nominal row: 64 sclk pulses with rgb0 = x[2:0], rgb1 = ~x[2:0], addry = 5, then latch -> exactly 64 pix_valid, pix_x 0..63 in order, pix_y = 5, data matching, one row_done, no errors, no frame_start.
- Frame: 32 rows with addry 0..31, sclk at clk/4 -> frame_start only on row 0; 2048 pixels total; shifting of row k+1 overlaps replay of row k with no corruption.
- Short/empty rows:
  - 10 sclk then latch -> 10 pixels (x 0..9), row_done.
  - Immediate second latch -> zero pixels, single row_done.
- Overflow: 70 sclk then latch -> 64 pixels equal to the first 64 shifted, err_overflow = 1, sticky until reset.
- Overrun: 64 sclk, latch, 3 sclk, latch within 20 clk -> err_overrun = 1; first row replays fully; second latch produces no replay; the next normal row works.
- Reset: assert reset during DUMP at pixel 30 -> pix_valid drops asynchronously and all outputs are 0; after release, a nominal row replays correctly.
